// File: rtl/wavelet_readout_sched.sv
// wavelet_readout_sched
//   Integrates the I/Q feedback pulse pairs of N_CH wavelet cores into signed
//   saturating per-path counters over frames of FRAME_LEN ud_en-qualified
//   cycles. At each frame end the totals are snapshotted and drained as a
//   serial word stream, ordered ch0 I, ch0 Q, ch1 I, ...
//
// Ports
//   clk_master  : system clock, all logic on the rising edge
//   rst         : synchronous active-high reset
//   ud_en       : count enable; frame counter and accumulators advance only when 1
//   read_out_I  : per channel c bits [2c+1:2c]; bit0 = fb+ pulse, bit1 = fb- pulse
//   read_out_Q  : same encoding for the Q path
//   out_valid   : out_data holds a valid word
//   out_ready   : downstream accepts the word
//   out_data    : {ch_idx, iq (0=I, 1=Q), snapshot[CNT_W-1:0]}
//   out_last    : high with the final word of a frame
//   frame_tick  : one-cycle pulse on the frame-end cycle (combinational)
//   overrun     : sticky; a frame ended while the previous one was still draining
//
// Handshake: a word transfers on every rising edge where out_valid & out_ready.
// While out_valid is high and out_ready low, out_data/out_last are held stable,
// and out_valid never drops until the word has been taken.
//
// N_CH is expected to be >= 2.

module wavelet_readout_sched #(
   parameter int N_CH      = 4,
   parameter int CNT_W     = 8,
   parameter int FRAME_LEN = 256
) (
   input  logic                              clk_master,
   input  logic                              rst,
   input  logic                              ud_en,
   input  logic [2*N_CH-1:0]                 read_out_I,
   input  logic [2*N_CH-1:0]                 read_out_Q,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [$clog2(N_CH)+CNT_W:0]       out_data,
   output logic                              out_last,
   output logic                              frame_tick,
   output logic                              overrun
);

   localparam int NW    = 2 * N_CH;            // number of paths / words per frame
   localparam int IDX_W = $clog2(N_CH) + 1;    // word index == {ch_idx, iq}
   localparam int FC_W  = $clog2(FRAME_LEN);
   localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [FC_W-1:0]         fcnt;
   logic [IDX_W-1:0]        idx;
   logic [IDX_W-1:0]        idx_nxt;
   logic [CNT_W-1:0]        acc  [NW];
   logic [CNT_W-1:0]        tot  [NW];
   logic [CNT_W-1:0]        snap [NW];
   logic                    frame_end;
   logic                    hs;
   logic                    last_idx;
   logic                    load;

   // acc + delta(p), clamped to the signed CNT_W range. Overflow shows up as a
   // disagreement between the extra sign bit and the result's MSB.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       p);
      logic [CNT_W:0] s;
      s = {a[CNT_W-1], a};
      if (p == 2'b01)      s = s + ONE;
      else if (p == 2'b10) s = s - ONE;
      if (s[CNT_W] != s[CNT_W-1])
         return s[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}};
      return s[CNT_W-1:0];
   endfunction

   // Path 2c is channel c I, path 2c+1 is channel c Q (same as word order).
   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         tot[2*c]   = sat_add(acc[2*c],   read_out_I[2*c +: 2]);
         tot[2*c+1] = sat_add(acc[2*c+1], read_out_Q[2*c +: 2]);
      end
   end

   assign frame_end  = ud_en && (fcnt == FC_W'(FRAME_LEN - 1));
   assign frame_tick = frame_end;
   assign out_valid  = (state_q == SEND);
   assign hs         = out_valid && out_ready;
   assign last_idx   = (idx == IDX_W'(NW - 1));
   assign idx_nxt    = idx + IDX_W'(1);

   // Frame counter and accumulators; cleared at frame end so the next frame
   // starts from zero.
   always_ff @(posedge clk_master) begin
      if (rst) begin
         fcnt <= '0;
         for (int k = 0; k < NW; k++) acc[k] <= '0;
      end else if (ud_en) begin
         fcnt <= frame_end ? '0 : fcnt + FC_W'(1);
         for (int k = 0; k < NW; k++) acc[k] <= frame_end ? '0 : tot[k];
      end
   end

   // Drain FSM: state register.
   always_ff @(posedge clk_master) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Drain FSM: next state. A frame is accepted when idle, or when the final
   // word of the current frame is handshaken in the frame-end cycle.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_end) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (hs && last_idx) begin
               if (frame_end) load    = 1'b1;
               else           state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot registers, word index and registered output word.
   always_ff @(posedge clk_master) begin
      if (rst) begin
         idx      <= '0;
         out_data <= '0;
         out_last <= 1'b0;
         overrun  <= 1'b0;
         for (int k = 0; k < NW; k++) snap[k] <= '0;
      end else begin
         if (frame_end && !load) overrun <= 1'b1;
         if (load) begin
            for (int k = 0; k < NW; k++) snap[k] <= tot[k];
            idx      <= '0;
            out_data <= {IDX_W'(0), tot[0]};
            out_last <= 1'b0;
         end else if (hs) begin
            if (last_idx) begin
               idx      <= '0;
               out_data <= '0;
               out_last <= 1'b0;
            end else begin
               idx      <= idx_nxt;
               out_data <= {idx_nxt, snap[idx_nxt]};
               out_last <= (idx_nxt == IDX_W'(NW - 1));
            end
         end
      end
   end

endmodule

// File: tb/tb_wavelet_readout_sched.sv
// tb_wavelet_readout_sched
//   Directed bench for wavelet_readout_sched with N_CH=2, CNT_W=4, FRAME_LEN=8.
//   Inputs change just after the falling edge; outputs are sampled 1 time unit
//   later, well away from the rising edge. Word format is {idx[1:0], total[3:0]}.

module tb_wavelet_readout_sched;

   localparam int N_CH      = 2;
   localparam int CNT_W     = 4;
   localparam int FRAME_LEN = 8;
   localparam int DW        = $clog2(N_CH) + 1 + CNT_W;

   logic              clk_master = 1'b0;
   logic              rst;
   logic              ud_en;
   logic [2*N_CH-1:0] read_out_I;
   logic [2*N_CH-1:0] read_out_Q;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic              frame_tick;
   logic              overrun;

   int checks = 0;
   int passes = 0;

   wavelet_readout_sched #(
      .N_CH(N_CH), .CNT_W(CNT_W), .FRAME_LEN(FRAME_LEN)
   ) dut (
      .clk_master (clk_master),
      .rst        (rst),
      .ud_en      (ud_en),
      .read_out_I (read_out_I),
      .read_out_Q (read_out_Q),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .frame_tick (frame_tick),
      .overrun    (overrun)
   );

   // clock
   always #5 clk_master = ~clk_master;

   task automatic tick();
      @(posedge clk_master);
      @(negedge clk_master);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      assert (got === exp) passes = passes + 1;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // n cycles with fixed enable/inputs; frame_tick expected only on the last
   // cycle when tick_last is set. Leaves ud_en and pulse inputs at 0.
   task automatic run_cycles(input int n, input logic en, input logic [3:0] vi,
                             input logic [3:0] vq, input logic tick_last);
      for (int i = 0; i < n; i++) begin
         ud_en      = en;
         read_out_I = vi;
         read_out_Q = vq;
         #1;
         chk("frame_tick", {31'd0, frame_tick}, {31'd0, (tick_last && i == n - 1)});
         tick();
      end
      ud_en      = 1'b0;
      read_out_I = '0;
      read_out_Q = '0;
   endtask

   // Drain four words with out_ready=1, then expect out_valid to drop.
   task automatic expect_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                               input logic [DW-1:0] w2, input logic [DW-1:0] w3);
      logic [DW-1:0] w [4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int i = 0; i < 4; i++) begin
         out_ready = 1'b1;
         #1;
         chk("drain_valid", {31'd0, out_valid}, 32'd1);
         chk("drain_data",  {26'd0, out_data},  {26'd0, w[i]});
         chk("drain_last",  {31'd0, out_last},  {31'd0, (i == 3)});
         tick();
      end
      #1;
      chk("idle_after_drain", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      // reset
      rst        = 1'b1;
      ud_en      = 1'b0;
      read_out_I = '0;
      read_out_Q = '0;
      out_ready  = 1'b1;
      tick();
      tick();
      #1;
      chk("rst_valid",   {31'd0, out_valid},  32'd0);
      chk("rst_data",    {26'd0, out_data},   32'd0);
      chk("rst_last",    {31'd0, out_last},   32'd0);
      chk("rst_tick",    {31'd0, frame_tick}, 32'd0);
      chk("rst_overrun", {31'd0, overrun},    32'd0);
      rst = 1'b0;

      // 1: basic frame; ch0 I +8 saturates to 7, ch1 Q -3 = 0xD
      run_cycles(3, 1'b1, 4'b0001, 4'b1000, 1'b0);
      run_cycles(5, 1'b1, 4'b0001, 4'b0000, 1'b1);
      expect_words(6'h07, 6'h10, 6'h20, 6'h3D);

      // 2: ch0 Q -8 (0x8), ch1 I code 11 gives 0
      run_cycles(8, 1'b1, 4'b1100, 4'b0010, 1'b1);
      expect_words(6'h00, 6'h18, 6'h20, 6'h30);

      // 3: backpressure; ch0 Q +5 proves accumulator restarted from 0, ch1 I +2
      run_cycles(2, 1'b1, 4'b0100, 4'b0001, 1'b0);
      run_cycles(3, 1'b1, 4'b0000, 4'b0001, 1'b0);
      run_cycles(3, 1'b1, 4'b0000, 4'b0000, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_data",  {26'd0, out_data},  32'h00);
         chk("bp_last",  {31'd0, out_last},  32'd0);
         tick();
      end
      expect_words(6'h00, 6'h15, 6'h22, 6'h30);

      // 4a: overrun; second frame ends while first (ch0 I = 3) is stalled
      run_cycles(3, 1'b1, 4'b0001, 4'b0000, 1'b0);
      run_cycles(5, 1'b1, 4'b0000, 4'b0000, 1'b1);
      out_ready = 1'b0;
      run_cycles(8, 1'b1, 4'b0000, 4'b0100, 1'b1);
      #1;
      chk("ovr_set",   {31'd0, overrun},   32'd1);
      chk("ovr_valid", {31'd0, out_valid}, 32'd1);
      chk("ovr_data",  {26'd0, out_data},  32'h03);
      expect_words(6'h03, 6'h10, 6'h20, 6'h30);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);

      // 4b: reset clears overrun, then last handshake coincides with frame end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);
      run_cycles(5, 1'b1, 4'b0001, 4'b0000, 1'b0);
      run_cycles(3, 1'b1, 4'b0000, 4'b0000, 1'b1);
      begin
         logic [DW-1:0] wb [4];
         wb[0] = 6'h05; wb[1] = 6'h10; wb[2] = 6'h20; wb[3] = 6'h30;
         for (int i = 0; i < 8; i++) begin
            ud_en      = 1'b1;
            read_out_I = 4'b1000;
            read_out_Q = 4'b0000;
            out_ready  = (i >= 4);
            #1;
            chk("sim_valid", {31'd0, out_valid},  32'd1);
            chk("sim_data",  {26'd0, out_data},   {26'd0, wb[(i < 4) ? 0 : i - 4]});
            chk("sim_last",  {31'd0, out_last},   {31'd0, (i == 7)});
            chk("sim_tick",  {31'd0, frame_tick}, {31'd0, (i == 7)});
            tick();
         end
      end
      ud_en      = 1'b0;
      read_out_I = '0;
      #1;
      chk("sim_no_idle", {31'd0, out_valid}, 32'd1);
      chk("sim_overrun", {31'd0, overrun},   32'd0);
      expect_words(6'h00, 6'h10, 6'h28, 6'h30);

      // 5: ud_en gap of 10 cycles with pulses still driven; total is 3, not 7
      run_cycles(3,  1'b1, 4'b0001, 4'b0000, 1'b0);
      run_cycles(10, 1'b0, 4'b0001, 4'b0000, 1'b0);
      run_cycles(5,  1'b1, 4'b0000, 4'b0000, 1'b1);
      expect_words(6'h03, 6'h10, 6'h20, 6'h30);

      // 6: reset mid-drain, then a clean frame
      run_cycles(2, 1'b1, 4'b0010, 4'b0100, 1'b0);
      run_cycles(4, 1'b1, 4'b0000, 4'b0100, 1'b0);
      run_cycles(2, 1'b1, 4'b0000, 4'b0000, 1'b1);
      out_ready = 1'b1;
      #1;
      chk("pre_rst_w0", {26'd0, out_data}, 32'h0E);
      tick();
      #1;
      chk("pre_rst_w1", {26'd0, out_data}, 32'h10);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid",   {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data",    {26'd0, out_data},  32'd0);
      chk("mid_rst_last",    {31'd0, out_last},  32'd0);
      chk("mid_rst_overrun", {31'd0, overrun},   32'd0);
      run_cycles(4, 1'b1, 4'b0100, 4'b0000, 1'b0);
      run_cycles(4, 1'b1, 4'b0000, 4'b0000, 1'b1);
      expect_words(6'h00, 6'h10, 6'h24, 6'h30);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
